// File: rtl/periferico_pkg.sv
// rtl/periferico_pkg.sv - shared codes and state type for the send/ack peripheral
package periferico_pkg;

   localparam logic [1:0] SEND_IDLE = 2'b00;
   localparam logic [1:0] SEND_REQ  = 2'b01;
   localparam logic [1:0] ACK_IDLE  = 2'b00;
   localparam logic [1:0] ACK_OK    = 2'b01;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACK  = 1'b1
   } state_t;

endpackage

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock FIFO with registered pop output
module fifo_sync #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      push_i,
   input  logic                      pop_i,
   input  logic [DATA_W-1:0]         din_i,
   output logic [DATA_W-1:0]         dout_o,
   output logic                      dout_valid_o,
   output logic [$clog2(DEPTH):0]    count_o,
   output logic                      full_o,
   output logic                      empty_o
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = ADDR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dout_valid_q, dout_valid_d;
   logic              do_push;
   logic              do_pop;

   // Flags come straight from the registered occupancy; full gates push on the pre-pop count.
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Pointer, occupancy and read-port next-state.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d     = rd_ptr_q + ADDR_W'(1);
         dout_d       = mem_q[rd_ptr_q];
         dout_valid_d = 1'b1;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Control registers; reset discards everything buffered.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   // Storage array; contents are meaningless once pointers are cleared, so no reset.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   assign dout_o       = dout_q;
   assign dout_valid_o = dout_valid_q;
   assign count_o      = count_q;

endmodule

// File: rtl/fsm_periferico.sv
// rtl/fsm_periferico.sv - send/ack handshake consumer feeding a small FIFO
module fsm_periferico
   import periferico_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        send,
   input  logic [DATA_W-1:0] dado,
   output logic [1:0]        ack,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              err
);

   state_t     state_q, state_d;
   logic [1:0] ack_q, ack_d;
   logic       err_q, err_d;
   logic       push;

   // Handshake decisions: one push per request, withheld while the FIFO is full.
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      push    = 1'b0;
      case (send)
         SEND_IDLE: begin
            state_d = S_IDLE;
         end
         SEND_REQ: begin
            if (state_q == S_IDLE && !full) begin
               push    = 1'b1;
               state_d = S_ACK;
            end
         end
         default: begin
            err_d = 1'b1;
         end
      endcase
      ack_d = (state_d == S_ACK) ? ACK_OK : ACK_IDLE;
   end

   // State, registered ack decode and sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ack_q   <= ACK_IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   assign ack = ack_q;
   assign err = err_q;

   fifo_sync #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk_i        (clk),
      .rst_i        (rst),
      .push_i       (push),
      .pop_i        (rd_en),
      .din_i        (dado),
      .dout_o       (rd_data),
      .dout_valid_o (rd_valid),
      .count_o      (count),
      .full_o       (full),
      .empty_o      (empty)
   );

endmodule

// File: tb/tb_fsm_periferico.sv
// tb/tb_fsm_periferico.sv - self-checking bench for fsm_periferico
module tb_fsm_periferico;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = $clog2(DEPTH);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [1:0]        send = 2'b00;
   logic [DATA_W-1:0] dado = '0;
   logic              rd_en = 1'b0;
   logic [1:0]        ack;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;
   logic              err;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   // Reference: a word queue, whether the current request was already answered, sticky error.
   logic [DATA_W-1:0] m_q[$];
   bit                m_answered = 1'b0;
   bit                m_err = 1'b0;
   bit                m_rd_valid = 1'b0;
   logic [DATA_W-1:0] m_rd_data = '0;

   fsm_periferico #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .send     (send),
      .dado     (dado),
      .ack      (ack),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_answered = 1'b0;
      m_err      = 1'b0;
      m_rd_valid = 1'b0;
      m_rd_data  = '0;
   endtask

   // One clock edge worth of the rules, applied to the values the DUT sampled.
   task automatic model_edge();
      bit was_full;
      was_full   = (m_q.size() == DEPTH);
      m_rd_valid = 1'b0;
      if (rd_en && m_q.size() > 0) begin
         m_rd_data  = m_q.pop_front();
         m_rd_valid = 1'b1;
      end
      if (send == 2'b01) begin
         if (!m_answered && !was_full) begin
            m_q.push_back(dado);
            m_answered = 1'b1;
         end
      end else if (send == 2'b00) begin
         m_answered = 1'b0;
      end else begin
         m_err = 1'b1;
      end
   endtask

   // Drive inputs, let one edge happen, return at the following falling edge.
   task automatic tick(input logic [1:0] s, input logic [DATA_W-1:0] d, input logic r);
      send  = s;
      dado  = d;
      rd_en = r;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset_check();
      #2;
      rst  = 1'b1;
      send = 2'b00;
      rd_en = 1'b0;
      model_reset();
      #1;
      check("rst_ack", 32'(ack), 32'h0);
      check("rst_count", 32'(count), 32'h0);
      check("rst_empty", 32'(empty), 32'h1);
      check("rst_full", 32'(full), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_rd_valid", 32'(rd_valid), 32'h0);
      check("rst_rd_data", 32'(rd_data), 32'h0);
      #1;
      rst = 1'b0;
   endtask

   // Cycle-by-cycle comparison against the reference.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en && !rst) begin
            check("cmp_ack", 32'(ack), (m_answered ? 32'h1 : 32'h0));
            check("cmp_count", 32'(count), 32'(m_q.size()));
            check("cmp_full", 32'(full), 32'(m_q.size() == DEPTH));
            check("cmp_empty", 32'(empty), 32'(m_q.size() == 0));
            check("cmp_err", 32'(err), 32'(m_err));
            check("cmp_rd_valid", 32'(rd_valid), 32'(m_rd_valid));
            check("cmp_rd_data", 32'(rd_data), 32'(m_rd_data));
         end
      end
   end

   initial begin
      logic [1:0] s;
      int         r;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("init_ack", 32'(ack), 32'h0);
      check("init_count", 32'(count), 32'h0);
      check("init_empty", 32'(empty), 32'h1);
      check("init_full", 32'(full), 32'h0);
      check("init_err", 32'(err), 32'h0);
      chk_en = 1'b1;

      // Single transfer
      tick(2'b01, 16'hA5C3, 1'b0);
      check("single_ack", 32'(ack), 32'h1);
      check("single_count", 32'(count), 32'h1);
      tick(2'b00, 16'h0000, 1'b0);
      check("single_ack_drop", 32'(ack), 32'h0);
      tick(2'b00, 16'h0000, 1'b1);
      check("single_rd_valid", 32'(rd_valid), 32'h1);
      check("single_rd_data", 32'(rd_data), 32'hA5C3);
      check("single_empty", 32'(empty), 32'h1);
      tick(2'b00, 16'h0000, 1'b0);
      check("single_rd_pulse", 32'(rd_valid), 32'h0);

      // Fill and backpressure
      for (int i = 1; i <= 4; i++) begin
         tick(2'b01, 16'(i), 1'b0);
         tick(2'b00, 16'h0000, 1'b0);
      end
      check("fill_full", 32'(full), 32'h1);
      check("fill_count", 32'(count), 32'h4);
      tick(2'b01, 16'h0005, 1'b0);
      check("bp_ack", 32'(ack), 32'h0);
      check("bp_count", 32'(count), 32'h4);
      tick(2'b01, 16'h0005, 1'b1);
      check("bp_pop_data", 32'(rd_data), 32'h0001);
      check("bp_pop_ack", 32'(ack), 32'h0);
      tick(2'b01, 16'h0005, 1'b0);
      check("bp_accept_ack", 32'(ack), 32'h1);
      check("bp_accept_count", 32'(count), 32'h4);
      tick(2'b00, 16'h0000, 1'b0);
      for (int i = 2; i <= 5; i++) begin
         tick(2'b00, 16'h0000, 1'b1);
         check("bp_drain", 32'(rd_data), 32'(i));
      end

      // Held request
      for (int i = 0; i < 10; i++) begin
         tick(2'b01, 16'h1234 + 16'(i), 1'b0);
         check("held_ack", 32'(ack), 32'h1);
      end
      check("held_count", 32'(count), 32'h1);
      tick(2'b00, 16'h0000, 1'b1);
      check("held_data", 32'(rd_data), 32'h1234);

      // Protocol error
      tick(2'b11, 16'hDEAD, 1'b0);
      check("perr_err", 32'(err), 32'h1);
      check("perr_count", 32'(count), 32'h0);
      check("perr_ack", 32'(ack), 32'h0);
      tick(2'b00, 16'h0000, 1'b0);
      check("perr_sticky", 32'(err), 32'h1);
      tick(2'b01, 16'hBEEF, 1'b0);
      check("perr_xfer_ack", 32'(ack), 32'h1);
      tick(2'b00, 16'h0000, 1'b1);
      check("perr_xfer_data", 32'(rd_data), 32'hBEEF);
      check("perr_still", 32'(err), 32'h1);

      // Simultaneous push and pop at one entry
      tick(2'b01, 16'h1111, 1'b0);
      tick(2'b00, 16'h0000, 1'b0);
      tick(2'b01, 16'h2222, 1'b1);
      check("simul_data", 32'(rd_data), 32'h1111);
      check("simul_count", 32'(count), 32'h1);
      check("simul_ack", 32'(ack), 32'h1);
      tick(2'b00, 16'h0000, 1'b1);
      check("simul_next", 32'(rd_data), 32'h2222);

      // Reset mid-handshake with three words buffered and err set
      tick(2'b01, 16'h00A1, 1'b0);
      tick(2'b00, 16'h0000, 1'b0);
      tick(2'b01, 16'h00A2, 1'b0);
      tick(2'b00, 16'h0000, 1'b0);
      tick(2'b01, 16'h00A3, 1'b0);
      check("pre_rst_ack", 32'(ack), 32'h1);
      check("pre_rst_count", 32'(count), 32'h3);
      check("pre_rst_err", 32'(err), 32'h1);
      do_reset_check();

      // Wrap-around
      for (int i = 1; i <= 10; i++) begin
         tick(2'b01, 16'(i), 1'b0);
         tick(2'b00, 16'h0000, 1'b1);
         check("wrap_data", 32'(rd_data), 32'(i));
      end
      check("wrap_last", 32'(rd_data), 32'h000A);

      // Randomized traffic against the reference
      for (int n = 0; n < 3000; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 2)       s = 2'(2 + $urandom_range(0, 1));
         else if (r < 55) s = 2'b01;
         else             s = 2'b00;
         tick(s, 16'($urandom), ($urandom_range(0, 2) == 0));
         if (n == 1500) do_reset_check();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
